// File: rtl/arith_sequencer_pkg.sv
// Shared definitions for the arithmetic machine sequencer.
// Holds the 3-bit FSM state encoding, so the top level and the bench
// decode the debug `state` port by name, and the default width of the
// retired-instruction counter.
package arith_sequencer_pkg;

   localparam int DEFAULT_COUNT_WIDTH = 32;

   // Codes 6 and 7 are unused; the FSM maps them back to ST_IDLE.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALTED    = 3'd5
   } state_t;

endpackage

// File: rtl/arith_sequencer_sat_counter.sv
// sat_counter: synchronous-reset up-counter with enable that holds at
// all-ones instead of wrapping.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high clear
//   enable      count up by one on this edge (unless saturated)
//   count       current value
//   next_count  value the counter takes on an enabled edge
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] next_count
);

   assign next_count = (&count) ? count : count + WIDTH'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         count <= next_count;
      end
   end

endmodule

// File: rtl/arith_sequencer.sv
// arith_sequencer: multi-cycle control FSM for the arithmetic machine.
// Each instruction walks FETCH -> DECODE -> EXECUTE -> WRITEBACK; the
// PC and the regfile are only written in WRITEBACK. Supports continuous
// run, single-step, stop-after-current, exception halt and a saturating
// retired-instruction count.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   start, step             begin run / single instruction (IDLE only)
//   stop                    stop once the in-flight instruction retires
//   clear_except            leave HALTED
//   dec_except              decoder exception for current instruction
//   dec_writeenable         decoder regfile write request
//   ir_load                 fetch strobe (FETCH)
//   pc_enable               PC advance (WRITEBACK)
//   rf_writeenable          regfile write (WRITEBACK and dec_writeenable)
//   busy, halted            status
//   except_latched          sticky exception flag
//   inst_count              retired instructions, saturating
//   state                   current FSM state code
module arith_sequencer
   import arith_sequencer_pkg::*;
#(
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
   parameter int MAX_INSTS   = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   step,
   input  logic                   stop,
   input  logic                   clear_except,
   input  logic                   dec_except,
   input  logic                   dec_writeenable,
   output logic                   ir_load,
   output logic                   pc_enable,
   output logic                   rf_writeenable,
   output logic                   busy,
   output logic                   halted,
   output logic                   except_latched,
   output logic [COUNT_WIDTH-1:0] inst_count,
   output logic [2:0]             state
);

   localparam logic [COUNT_WIDTH-1:0] MAX_CMP = COUNT_WIDTH'(MAX_INSTS);

   state_t                 state_q;
   logic                   step_mode;
   logic                   stop_pending;
   logic                   ir_load_q;
   logic                   wb_q;
   logic [COUNT_WIDTH-1:0] count_inc;
   logic                   limit_hit;

   sat_counter #(.WIDTH(COUNT_WIDTH)) u_inst_count (
      .clock      (clock),
      .reset      (reset),
      .enable     (state_q == ST_WRITEBACK),
      .count      (inst_count),
      .next_count (count_inc)
   );

   // Compare against the post-increment value so the run stops on the
   // retirement that reaches the limit.
   assign limit_hit = (MAX_INSTS != 0) && (count_inc == MAX_CMP);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         except_latched <= 1'b0;
         step_mode      <= 1'b0;
         stop_pending   <= 1'b0;
         ir_load_q      <= 1'b0;
         wb_q           <= 1'b0;
      end else begin
         // Strobe registers track the state being entered.
         ir_load_q <= 1'b0;
         wb_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               stop_pending <= 1'b0;
               if (start) begin
                  state_q   <= ST_FETCH;
                  step_mode <= 1'b0;
                  ir_load_q <= 1'b1;
               end else if (step) begin
                  state_q   <= ST_FETCH;
                  step_mode <= 1'b1;
                  ir_load_q <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (stop) stop_pending <= 1'b1;
               state_q <= ST_DECODE;
            end
            ST_DECODE: begin
               if (stop) stop_pending <= 1'b1;
               if (dec_except) begin
                  state_q        <= ST_HALTED;
                  except_latched <= 1'b1;
               end else begin
                  state_q <= ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               if (stop) stop_pending <= 1'b1;
               state_q <= ST_WRITEBACK;
               wb_q    <= 1'b1;
            end
            ST_WRITEBACK: begin
               stop_pending <= 1'b0;
               if (step_mode || stop_pending || stop || limit_hit) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q   <= ST_FETCH;
                  ir_load_q <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (clear_except) begin
                  state_q        <= ST_IDLE;
                  except_latched <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Strobes are masked by reset so an abandoned instruction never
   // advances the PC or writes the regfile in the reset cycle.
   assign ir_load        = ir_load_q & ~reset;
   assign pc_enable      = wb_q & ~reset;
   assign rf_writeenable = wb_q & dec_writeenable & ~reset;

   assign busy   = (state_q == ST_FETCH)   || (state_q == ST_DECODE) ||
                   (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);
   assign halted = (state_q == ST_HALTED);
   assign state  = state_q;

endmodule

// File: tb/tb_arith_sequencer.sv
module tb_arith_sequencer;
   import arith_sequencer_pkg::*;

   logic clock = 1'b0;
   logic reset, start, step, stop, clear_except, dec_except, dec_writeenable;

   // Default instance: 32-bit count, unlimited run.
   logic        a_ir, a_pc, a_we, a_busy, a_halt, a_exc;
   logic [31:0] a_cnt;
   logic [2:0]  a_st;
   // Auto-stop after 3 retirements.
   logic        l_ir, l_pc, l_we, l_busy, l_halt, l_exc;
   logic [31:0] l_cnt;
   logic [2:0]  l_st;
   // 2-bit saturating count.
   logic        w_ir, w_pc, w_we, w_busy, w_halt, w_exc;
   logic [1:0]  w_cnt;
   logic [2:0]  w_st;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   arith_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .step(step), .stop(stop),
      .clear_except(clear_except), .dec_except(dec_except),
      .dec_writeenable(dec_writeenable), .ir_load(a_ir), .pc_enable(a_pc),
      .rf_writeenable(a_we), .busy(a_busy), .halted(a_halt),
      .except_latched(a_exc), .inst_count(a_cnt), .state(a_st));

   arith_sequencer #(.COUNT_WIDTH(32), .MAX_INSTS(3)) dut_lim (
      .clock(clock), .reset(reset), .start(start), .step(step), .stop(stop),
      .clear_except(clear_except), .dec_except(dec_except),
      .dec_writeenable(dec_writeenable), .ir_load(l_ir), .pc_enable(l_pc),
      .rf_writeenable(l_we), .busy(l_busy), .halted(l_halt),
      .except_latched(l_exc), .inst_count(l_cnt), .state(l_st));

   arith_sequencer #(.COUNT_WIDTH(2), .MAX_INSTS(0)) dut_w2 (
      .clock(clock), .reset(reset), .start(start), .step(step), .stop(stop),
      .clear_except(clear_except), .dec_except(dec_except),
      .dec_writeenable(dec_writeenable), .ir_load(w_ir), .pc_enable(w_pc),
      .rf_writeenable(w_we), .busy(w_busy), .halted(w_halt),
      .except_latched(w_exc), .inst_count(w_cnt), .state(w_st));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit before sampling/driving.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0; step = 1'b0; stop = 1'b0; clear_except = 1'b0;
      dec_except = 1'b0; dec_writeenable = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] mask;
      logic [31:0] seen;

      // ---- reset state
      do_reset();
      chk("rst_state", 32'(a_st), 32'(ST_IDLE));
      chk("rst_count", a_cnt, 32'd0);
      chk("rst_exc", 32'(a_exc), 32'd0);
      chk("rst_strobes", {29'd0, a_ir, a_pc, a_we}, 32'd0);
      chk("rst_busy_halt", {30'd0, a_busy, a_halt}, 32'd0);

      // ---- single step
      step = 1'b1;
      tick();                              // cycle 1
      step = 1'b0;
      chk("step_c1_state", 32'(a_st), 32'(ST_FETCH));
      chk("step_c1_ir_load", 32'(a_ir), 32'd1);
      chk("step_c1_busy", 32'(a_busy), 32'd1);
      tick(); tick(); tick();              // cycle 4
      chk("step_c4_state", 32'(a_st), 32'(ST_WRITEBACK));
      chk("step_c4_pc_enable", 32'(a_pc), 32'd1);
      chk("step_c4_rf_we", 32'(a_we), 32'd1);
      chk("step_c4_count_before", a_cnt, 32'd0);
      tick();                              // cycle 5
      chk("step_c5_state", 32'(a_st), 32'(ST_IDLE));
      chk("step_c5_count", a_cnt, 32'd1);
      chk("step_c5_pc_enable", 32'(a_pc), 32'd0);

      // ---- write gated by dec_writeenable=0
      step = 1'b1;
      dec_writeenable = 1'b0;
      tick();
      step = 1'b0;
      tick(); tick(); tick();
      chk("nowr_pc_enable", 32'(a_pc), 32'd1);
      chk("nowr_rf_we", 32'(a_we), 32'd0);
      dec_writeenable = 1'b1;
      tick();
      chk("nowr_count", a_cnt, 32'd2);

      // ---- MAX_INSTS=3 auto-stop
      do_reset();
      start = 1'b1;
      tick();                              // cycle 1
      start = 1'b0;
      mask = '0;
      for (int c = 1; c <= 20; c++) begin
         if (l_pc) mask[c] = 1'b1;
         tick();
      end
      chk("lim_pc_pulses", mask, 32'h0000_1110);
      chk("lim_state", 32'(l_st), 32'(ST_IDLE));
      chk("lim_count", l_cnt, 32'd3);

      // ---- stop during DECODE of the 2nd instruction
      do_reset();
      start = 1'b1;
      tick();                              // cycle 1
      start = 1'b0;
      tick(); tick(); tick(); tick(); tick(); // cycle 6
      chk("stop_c6_state", 32'(a_st), 32'(ST_DECODE));
      stop = 1'b1;
      tick();                              // cycle 7
      stop = 1'b0;
      tick();                              // cycle 8
      chk("stop_c8_pc_enable", 32'(a_pc), 32'd1);
      tick();                              // cycle 9
      chk("stop_c9_state", 32'(a_st), 32'(ST_IDLE));
      chk("stop_c9_count", a_cnt, 32'd2);

      // ---- decoder exception
      do_reset();
      start = 1'b1;
      tick();                              // cycle 1 FETCH
      start = 1'b0;
      tick();                              // cycle 2 DECODE
      dec_except = 1'b1;
      seen = '0;
      tick();                              // cycle 3
      dec_except = 1'b0;
      chk("exc_state", 32'(a_st), 32'(ST_HALTED));
      chk("exc_flag", 32'(a_exc), 32'd1);
      chk("exc_halted", 32'(a_halt), 32'd1);
      start = 1'b1;
      step = 1'b1;
      for (int c = 0; c < 4; c++) begin
         seen = seen | {30'd0, a_pc, a_we};
         tick();
      end
      start = 1'b0;
      step = 1'b0;
      chk("exc_no_strobes", seen, 32'd0);
      chk("exc_stays_halted", 32'(a_st), 32'(ST_HALTED));
      chk("exc_count", a_cnt, 32'd0);
      clear_except = 1'b1;
      tick();
      clear_except = 1'b0;
      chk("exc_clear_state", 32'(a_st), 32'(ST_IDLE));
      chk("exc_clear_flag", 32'(a_exc), 32'd0);

      // ---- start and step together -> run mode
      do_reset();
      start = 1'b1;
      step = 1'b1;
      tick();
      start = 1'b0;
      step = 1'b0;
      tick(); tick(); tick(); tick();      // cycle 5
      chk("both_c5_state", 32'(a_st), 32'(ST_FETCH));
      chk("both_c5_count", a_cnt, 32'd1);

      // ---- reset during EXECUTE
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();                      // cycle 3 EXECUTE
      chk("rexe_state", 32'(a_st), 32'(ST_EXECUTE));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rexe_state_after", 32'(a_st), 32'(ST_IDLE));
      chk("rexe_count", a_cnt, 32'd0);
      seen = '0;
      for (int c = 0; c < 6; c++) begin
         seen = seen | {31'd0, a_pc};
         tick();
      end
      chk("rexe_no_pc_enable", seen, 32'd0);

      // ---- reset during WRITEBACK masks the strobes
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();              // cycle 4 WRITEBACK
      reset = 1'b1;
      #1;
      chk("rwb_strobes", {30'd0, a_pc, a_we}, 32'd0);
      tick();
      reset = 1'b0;
      chk("rwb_state", 32'(a_st), 32'(ST_IDLE));
      chk("rwb_count", a_cnt, 32'd0);

      // ---- 2-bit counter saturates
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 20; c++) tick(); // five retirements
      chk("sat_w2_count", 32'(w_cnt), 32'd3);
      chk("sat_ref_count", a_cnt, 32'd5);
      chk("sat_w2_running", 32'(w_st), 32'(ST_FETCH));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick(); tick(); tick();
      chk("sat_w2_stopped", 32'(w_st), 32'(ST_IDLE));
      chk("sat_w2_count_final", 32'(w_cnt), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arith_sequencer.md
Name: arith_sequencer

Overview:
Multi-cycle control FSM for the arithmetic machine datapath (PC register, instruction memory, regfile, decoder, ALU). It sequences each instruction through fetch/decode/execute/writeback, and gates the PC register enable and the regfile write enable. It supports run, single-step and stop requests, latches decoder exceptions into a halted state, and counts retired instructions.

Parameters:
COUNT_WIDTH, 32, width of the retired-instruction counter
MAX_INSTS, 0, auto-stop after this many retirements in run mode; 0 = unlimited

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; returns the block to IDLE
start  input  1  begin continuous execution (sampled in IDLE only)
step  input  1  execute exactly one instruction (sampled in IDLE only)
stop  input  1  request stop after the current instruction retires
clear_except  input  1  leave HALTED (sampled in HALTED only)
dec_except  input  1  decoder exception flag for the current instruction
dec_writeenable  input  1  decoder regfile write request
ir_load  output  1  instruction register / fetch strobe
pc_enable  output  1  PC register enable
rf_writeenable  output  1  gated regfile write enable
busy  output  1  high in FETCH, DECODE, EXECUTE or WRITEBACK
halted  output  1  high in HALTED
except_latched  output  1  sticky exception flag
inst_count  output  COUNT_WIDTH  retired instructions, saturating
state  output  3  current FSM state, for debug and bench

Behaviour:
- Reset (synchronous, active-high, priority over all inputs): state=IDLE; inst_count=0; except_latched=0; step_mode=0; stop_pending=0. All strobes are low.
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- IDLE: start=1 -> FETCH with step_mode=0. Otherwise step=1 -> FETCH with step_mode=1. start wins when both are high. stop is ignored and stop_pending is cleared.
- FETCH: ir_load=1 -> DECODE.
- DECODE: dec_except=1 -> HALTED and set except_latched=1, with no PC advance and no write. Otherwise -> EXECUTE.
- EXECUTE: no strobes (ALU settles) -> WRITEBACK.
- WRITEBACK: pc_enable=1; rf_writeenable=dec_writeenable (combinational AND with state, the only Mealy output); inst_count increments, saturating at all-ones.
  - Goes to IDLE if step_mode=1, or stop_pending=1, or stop=1 this cycle, or (MAX_INSTS!=0 and the post-increment count equals MAX_INSTS). Otherwise -> FETCH.
  - stop_pending clears on leaving WRITEBACK.
- stop sampled high in FETCH, DECODE or EXECUTE sets stop_pending. The in-flight instruction always completes.
- HALTED: all strobes low. clear_except=1 -> IDLE and clear except_latched. Nothing else leaves HALTED except reset.
- Timing: start high at edge t gives FETCH in cycle t+1, pc_enable and the write in cycle t+4, and the next FETCH in cycle t+5. Throughput is 4 cycles per instruction.
- pc_enable, rf_writeenable and ir_load are never high outside their states, and never high in the same cycle as reset.
- Reset mid-instruction abandons it: no write and no PC advance in the reset cycle.
- MAX_INSTS=0: the limit comparison is disabled.

Decomposition:
- Shared package holds the state encoding localparams (ST_IDLE..ST_HALTED, 3-bit) and the COUNT_WIDTH default, so the bench decodes `state` symbolically.
- One natural sub-module: sat_counter #(WIDTH), a synchronous reset counter with enable and saturation, used for inst_count.

Test Plan:
- Reset, then step pulse -> ir_load in cycle 1, pc_enable in cycle 4, IDLE in cycle 5, inst_count=1, rf_writeenable matches dec_writeenable=1.
- start with MAX_INSTS=3 -> exactly 3 pc_enable pulses spaced 4 cycles apart, then IDLE, inst_count=3.
- Run, stop pulsed in the DECODE of the 2nd instruction -> 2nd instruction retires (pc_enable high), then IDLE, inst_count=2.
- dec_except=1 in DECODE of the 1st instruction -> HALTED, except_latched=1, no pc_enable or write. clear_except -> IDLE, flag=0.
- start and step high together in IDLE -> run mode continues past the first retirement.
- Reset asserted during EXECUTE -> next cycle IDLE, inst_count=0, no pc_enable observed. COUNT_WIDTH=2 run of 5 instructions -> inst_count stays at 3.
